fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch front end that produces the instruction/PCi pair consumed by InstructionDecoder.
//  Generates PC, requests words from instruction memory over a req/ack handshake, buffers responses
//  in a small FIFO, honours decode stall, and redirects/flushes on a taken branch.
// PARAMETERS
//  bus      32        data/address width
//  DEPTH    2         fetch FIFO entries (power of 2, >=2)
//  RESET_PC 32'h0     PC after reset
//  PC_STEP  4         byte increment per instruction
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     asynchronous, active-low reset
//  imem_req       out  1     memory request valid
//  imem_addr      out  bus   request address (byte)
//  imem_ack       in   1     response valid; rdata valid same cycle
//  imem_rdata     in   32    instruction word
//  stall          in   1     decode cannot accept this cycle
//  branch_taken   in   1     redirect strobe (1 cycle)
//  branch_target  in   bus   redirect PC
//  instruction    out  32    to decoder; NOP_INSTR when valid=0
//  PCo            out  bus   PC of instruction
//  valid          out  1     instruction/PCo hold a real instruction
// BEHAVIOUR
//  Reset (async, rst=0): fetch_pc=RESET_PC, FIFO empty, state=FETCH, imem_req=0, imem_addr=RESET_PC,
//   instruction=NOP_INSTR, PCo=0, valid=0. First imem_req asserts 1st cycle after rst deasserts.
//  States: FETCH (may issue), WAIT (1 request outstanding), DROP (outstanding response to discard).
//  FETCH: imem_req=1, imem_addr=fetch_pc iff count<DEPTH. Handshake completes when imem_ack=1
//   while imem_req=1 (zero-wait ack allowed): push {fetch_pc, rdata}, fetch_pc+=PC_STEP, stay FETCH.
//   No ack -> WAIT; req/addr held stable until ack.
//  WAIT: req=1, addr stable; on ack push and return to FETCH. Max one request outstanding.
//  Push never overflows: request only issued when count<DEPTH counting same-cycle pop as free slot.
//  Output: valid=(count!=0); instruction/PCo=FIFO head, combinational from registered FIFO.
//   Pop when valid && !stall. Simultaneous push+pop: count unchanged.
//  stall with empty FIFO: no effect. stall never blocks fetching while space remains.
//  PC arithmetic: modulo 2^bus, wraps from 2^bus-PC_STEP to 0 silently.
//  branch_taken (priority over stall, ack, push): FIFO flushed (count=0, head discarded same cycle,
//   valid=0 next cycle), fetch_pc=branch_target.
//   - no request outstanding, or ack in same cycle: next state FETCH; response discarded.
//   - request outstanding, no ack: next state DROP; req deasserted; next ack dropped, then FETCH.
//   - branch while DROP: update fetch_pc, stay DROP.
//  First instruction from target visible on valid >=2 cycles after branch_taken (zero-wait memory).
//  Misaligned branch_target: fetched as given, no exception.
//  Latency: zero-wait memory, empty FIFO -> instruction valid 1 cycle after ack edge.
//  Reset mid-transaction: all state cleared; late imem_ack after reset ignored (no req outstanding).
// STRUCTURE
//  Package isa_pkg: NOP_INSTR (32'h0 with valid=0 gating), fetch_state_t enum {FETCH,WAIT,DROP},
//   PC_STEP constant, instruction field positions shared with InstructionDecoder.
//  Sub-module fetch_fifo #(W,DEPTH): sync FIFO, push/pop/flush, count, head out; flush wins over push.
//  Top: FSM + PC register + request logic.
// TESTING
//  1 Reset, zero-wait mem (ack=req, rdata=addr) -> addrs 0,4,8,C..; valid from cycle 2, PCo 0,4,8 consecutive.
//  2 stall=1 for 5 cycles after 3 fetches -> count saturates at 2, req=0, PCo held 0; release -> 4,8 in order, none lost.
//  3 Ack delayed 3 cycles -> imem_addr stable, req held, single push per ack; valid gaps match.
//  4 branch_taken target=0x40 while WAIT -> state DROP, stale ack discarded, next addr 0x40, PCo=0x40 first valid.
//  5 branch with simultaneous ack and stall -> FIFO empty, valid=0 next cycle, ack data never appears on outputs.
//  6 rst asserted mid-WAIT with later ack -> outputs at reset values, first req addr RESET_PC; PC wrap 0xFFFFFFFC->0.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared fetch/decode definitions: NOP encoding, fetch FSM states, instruction field positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package isa_pkg;

  // Placed on the decoder bus whenever no real instruction is present.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Byte increment between sequential instructions.
  localparam int PC_STEP_DEF = 4;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    FETCH = 2'd0,  // free to issue a request
    WAIT  = 2'd1,  // one request outstanding, address held
    DROP  = 2'd2   // outstanding response belongs to a squashed path
  } fetch_state_t;

  // Instruction field positions, shared with the decoder.
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instruction} entries; head is visible combinationally.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: none internally; the caller only pushes when a slot is free. Flush beats push and pop.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);

  // Storage write; contents need no reset because the head is qualified by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers and occupancy; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, req/ack memory fetch, small FIFO to the decoder, branch redirect.
// Latency: zero-wait memory into an empty FIFO gives valid one cycle after the ack edge.
// Backpressure: stall holds the head; new requests issue only while a FIFO slot is (or becomes) free.
module fetch_unit
  import isa_pkg::*;
#(
  parameter int             bus      = 32,
  parameter int             DEPTH    = 2,
  parameter logic [bus-1:0] RESET_PC = '0,
  parameter int             PC_STEP  = PC_STEP_DEF
) (
  input  logic           clk,
  input  logic           rst,
  output logic           imem_req,
  output logic [bus-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [31:0]    imem_rdata,
  input  logic           stall,
  input  logic           branch_taken,
  input  logic [bus-1:0] branch_target,
  output logic [31:0]    instruction,
  output logic [bus-1:0] PCo,
  output logic           valid
);

  localparam int             CW   = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);
  localparam int             EW   = bus + 32;

  fetch_state_t   state;
  fetch_state_t   state_nxt;
  logic [bus-1:0] fetch_pc;
  logic           fetch_en;
  logic [CW-1:0]  count;
  logic [EW-1:0]  head_dat;
  logic           hs;
  logic           push;
  logic           pop;
  logic           space;

  // Handshake completes whenever ack meets an asserted request.
  assign hs    = imem_req && imem_ack;
  // A squashed-path response never reaches the FIFO.
  assign push  = hs && !branch_taken;
  assign pop   = valid && !stall;
  // A slot being vacated this cycle counts as free.
  assign space = (count < FULL) || pop;

  assign valid       = (count != '0);
  assign instruction = valid ? head_dat[31:0] : NOP_INSTR;
  assign PCo         = valid ? head_dat[EW-1:32] : '0;
  assign imem_addr   = fetch_pc;

  // Holds requests off for one cycle after reset release so req never races the release edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_en <= 1'b0;
    end else begin
      fetch_en <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: an unanswered request becomes WAIT, or DROP if its path was squashed.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: begin
        if (imem_req && !imem_ack) begin
          state_nxt = branch_taken ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          state_nxt = FETCH;
        end else if (branch_taken) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  // FSM outputs: request while waiting, or when idle with room in the FIFO.
  always_comb begin
    imem_req = 1'b0;
    unique case (state)
      FETCH:   imem_req = fetch_en && space;
      WAIT:    imem_req = 1'b1;
      DROP:    imem_req = 1'b0;
      default: imem_req = 1'b0;
    endcase
  end

  // PC register: redirect has priority; otherwise advance on each accepted word (wraps modulo 2^bus).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
    end else if (branch_taken) begin
      fetch_pc <= branch_target;
    end else if (push) begin
      fetch_pc <= fetch_pc + bus'(PC_STEP);
    end
  end

  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({fetch_pc, imem_rdata}),
    .pop      (pop),
    .flush    (branch_taken),
    .head_dat (head_dat),
    .count    (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with programmable ack delay, in-order PC scoreboard.
// Latency: n/a.
// Backpressure: stall driven directly by the stimulus sequence.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic [31:0] PCo;
  logic        valid;

  int tests_run = 0;
  int errors    = 0;
  int cons_cnt  = 0;

  logic [31:0] sb_q[$];

  // Memory model state
  int          mem_delay;
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_lat;
  logic        mem_ack;
  logic        force_ack;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instruction   (instruction),
    .PCo           (PCo),
    .valid         (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected in-order instruction stream starting at pc.
  task automatic sb_restart(input logic [31:0] pc);
    sb_q.delete();
    for (int i = 0; i < 64; i++) sb_q.push_back(pc + 32'(4 * i));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_consumed(input string tag, input int n, input int budget);
    int target;
    target = cons_cnt + n;
    for (int i = 0; i < budget && cons_cnt < target; i++) @(posedge clk);
    #1;
    check(tag, 32'(cons_cnt >= target), 32'd1);
  endtask

  // Memory: answers each request after mem_delay cycles (0 = same cycle), even if req drops meanwhile.
  assign mem_ack    = mem_pend ? (mem_cnt >= mem_delay) : (imem_req && (mem_delay == 0));
  assign imem_ack   = mem_ack || force_ack;
  assign imem_rdata = force_ack ? 32'hDEAD_BEEF : fdat(mem_pend ? mem_lat : imem_addr);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_pend <= 1'b0;
      mem_cnt  <= 0;
      mem_lat  <= '0;
    end else if (mem_ack) begin
      mem_pend <= 1'b0;
      mem_cnt  <= 0;
    end else if (mem_pend) begin
      mem_cnt <= mem_cnt + 1;
    end else if (imem_req) begin
      mem_pend <= 1'b1;
      mem_cnt  <= 1;
      mem_lat  <= imem_addr;
    end
  end

  // Monitor: pops the scoreboard on every consumed instruction; checks NOP gating and address hold.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_pend && imem_req) check("addr_stable", imem_addr, mem_lat);
      if (!valid) begin
        check("nop_instr", instruction, 32'h0);
        check("nop_pco", PCo, 32'h0);
      end else if (!stall && !branch_taken) begin
        check("sb_avail", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          logic [31:0] e;
          e = sb_q.pop_front();
          check("pco", PCo, e);
          check("instr", instruction, fdat(e));
        end
        cons_cnt++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, required end of stimulus");
    $display("[TB] %0d tests run, %0d failed", tests_run, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int          gaps;
    bit          found;
    bit          stale_seen;

    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    force_ack = 1'b0; mem_delay = 0;
    sb_restart(32'h0);

    // Reset state
    cyc(3);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_pco", PCo, 32'h0);

    // 1: zero-wait sequential fetch
    rst = 1'b1;
    cyc(1);
    check("t1_valid_c1", 32'(valid), 32'd0);
    check("t1_req_c1", 32'(imem_req), 32'd1);
    check("t1_addr_c1", imem_addr, 32'h0);
    cyc(1);
    check("t1_valid_c2", 32'(valid), 32'd1);
    check("t1_pco_c2", PCo, 32'h0);
    check("t1_addr_c2", imem_addr, 32'h4);
    wait_consumed("t1_progress", 6, 50);

    // 2: stall saturates the FIFO, nothing lost on release
    stall = 1'b1;
    cyc(1);
    held = PCo;
    cyc(4);
    check("t2_req_full", 32'(imem_req), 32'd0);
    check("t2_valid", 32'(valid), 32'd1);
    check("t2_pco_held", PCo, held);
    check("t2_head_exp", PCo, sb_q[0]);
    stall = 1'b0;
    wait_consumed("t2_progress", 6, 50);

    // 3: ack delayed 3 cycles
    mem_delay = 3;
    gaps = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(1);
      if (!valid) gaps++;
    end
    check("t3_gaps_seen", 32'(gaps > 0), 32'd1);
    wait_consumed("t3_progress", 3, 60);

    // 4: branch while a request is outstanding -> stale response dropped
    mem_delay = 4;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      cyc(1);
      if (mem_pend && mem_cnt == 1 && imem_req && !imem_ack) found = 1'b1;
    end
    check("t4_wait_found", 32'(found), 32'd1);
    branch_taken = 1'b1; branch_target = 32'h40;
    sb_restart(32'h40);
    cyc(1);
    branch_taken = 1'b0;
    #1;
    check("t4_req_drop", 32'(imem_req), 32'd0);
    check("t4_valid_flushed", 32'(valid), 32'd0);
    stale_seen = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (mem_ack && !imem_req) stale_seen = 1'b1;
      if (imem_req) found = 1'b1;
      else cyc(1);
    end
    check("t4_stale_ack", 32'(stale_seen), 32'd1);
    check("t4_req_again", 32'(found), 32'd1);
    check("t4_target_addr", imem_addr, 32'h40);
    wait_consumed("t4_progress", 3, 80);

    // 5: branch together with same-cycle ack and stall
    mem_delay = 0;
    cyc(6);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
    sb_restart(32'h100);
    #1;
    check("t5_ack_same", 32'(imem_ack && imem_req), 32'd1);
    cyc(1);
    stall = 1'b0; branch_taken = 1'b0;
    #1;
    check("t5_valid_next", 32'(valid), 32'd0);
    check("t5_pco_next", PCo, 32'h0);
    check("t5_addr_target", imem_addr, 32'h100);
    wait_consumed("t5_progress", 4, 50);

    // 6: reset mid-WAIT with a late ack, then PC wrap
    mem_delay = 100;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (mem_pend && imem_req) found = 1'b1;
    end
    check("t6_wait_found", 32'(found), 32'd1);
    rst = 1'b0;
    sb_restart(32'h0);
    #1;
    check("t6_rst_req", 32'(imem_req), 32'd0);
    check("t6_rst_addr", imem_addr, 32'h0);
    check("t6_rst_valid", 32'(valid), 32'd0);
    check("t6_rst_instr", instruction, 32'h0);
    force_ack = 1'b1;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    force_ack = 1'b0; mem_delay = 0;
    #1;
    check("t6_valid_after", 32'(valid), 32'd0);
    check("t6_first_req", 32'(imem_req), 32'd1);
    check("t6_first_addr", imem_addr, 32'h0);
    wait_consumed("t6_progress", 4, 40);
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFF8;
    sb_restart(32'hFFFF_FFF8);
    cyc(1);
    branch_taken = 1'b0;
    wait_consumed("t6_wrap", 6, 50);

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, errors);
    $finish;
  end

endmodule
